// File: rtl/store_queue.sv
// -----------------------------------------------------------------------------
// store_queue
//
// Post-commit byte store buffer. Stores from the MEM stage enter a circular
// FIFO, and they drain to a byte-wide RAM write port whenever that port is
// free. Stores leave the queue in the order they entered it, and a queue
// entry is never discarded. A load or fetch byte can probe the queue with
// chk_addr. On a hit, the requester stalls until the matching store has
// reached the RAM.
//
// Ports
//   clock       rising-edge clock for all state
//   reset       synchronous, active-high; drops all pending stores
//   st_valid    a committed byte store is offered this cycle
//   st_addr     byte address of the offered store
//   st_data     byte data of the offered store
//   st_ready    the offered store is accepted this cycle (== !full)
//   ram_grant   RAM port is free for a write this cycle
//   ram_we      RAM write strobe (the head entry drains this cycle)
//   ram_addr    RAM write address (0 when not draining)
//   ram_w_data  RAM write data (0 when not draining)
//   chk_addr    byte address of a pending load/fetch byte
//   chk_hit     chk_addr matches a queued or incoming store
//   count       number of valid entries
//   empty       count == 0
//   full        count == DEPTH
//
// DEPTH must be a power of two and at least 2. The pointers then wrap
// naturally at their own width, and no modulo logic is needed.
// -----------------------------------------------------------------------------
module store_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     st_valid,
    input  logic [31:0]              st_addr,
    input  logic [7:0]               st_data,
    output logic                     st_ready,

    input  logic                     ram_grant,
    output logic                     ram_we,
    output logic [31:0]              ram_addr,
    output logic [7:0]               ram_w_data,

    input  logic [31:0]              chk_addr,
    output logic                     chk_hit,

    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry storage, indexed by head/tail.
    logic [31:0]      addr_mem [DEPTH];
    logic [7:0]       data_mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic             enq;
    logic             drain;
    logic [DEPTH-1:0] entry_valid;
    logic             queue_hit;
    logic             incoming_hit;

    // -------------------------------------------------------------------------
    // Status flags. These come only from the registered count. A full queue
    // therefore refuses a store even when a drain frees a slot in the same
    // cycle, and the store must be offered again.
    // -------------------------------------------------------------------------
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign st_ready = !full;

    // Reset blocks both queue operations. ram_we therefore stays low during
    // every reset cycle, even when entries were pending.
    assign enq   = st_valid && st_ready && !reset;
    assign drain = ram_grant && !empty && !reset;

    // -------------------------------------------------------------------------
    // Drain port: the head entry is presented combinationally. The bus is
    // zeroed when no drain is active, so stale entries never appear on it.
    // -------------------------------------------------------------------------
    assign ram_we     = drain;
    assign ram_addr   = drain ? addr_mem[head] : '0;
    assign ram_w_data = drain ? data_mem[head] : '0;

    // -------------------------------------------------------------------------
    // Occupancy mask. Slot i holds a live store when its distance from head,
    // modulo DEPTH, is less than count. This one rule covers wrapped and
    // unwrapped occupancy without special cases.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch or
        // loop; a path that leaves it unassigned would infer a latch.
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = ({1'b0, PTR_W'(PTR_W'(i) - head)} < count);
        end
    end

    // -------------------------------------------------------------------------
    // Hazard check. The entry that drains this cycle is still in the mask
    // (head moves only at the edge). A requester therefore keeps stalling
    // until the write has actually reached the RAM.
    // -------------------------------------------------------------------------
    always_comb begin
        queue_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (addr_mem[i] == chk_addr)) begin
                queue_hit = 1'b1;
            end
        end
    end

    // A store accepted this cycle is not in the mask yet. It must still block
    // a same-address read, because that read would otherwise see stale RAM
    // data.
    assign incoming_hit = st_valid && st_ready && (st_addr == chk_addr);
    assign chk_hit      = queue_hit || incoming_hit;

    // -------------------------------------------------------------------------
    // Pointer and count registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only. Every
        // register then samples the pre-edge values, whatever the order of
        // the statements.
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PTR_W'(1);
            end
            if (drain) begin
                head <= head + PTR_W'(1);
            end
            case ({enq, drain})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Entry storage write.
    // -------------------------------------------------------------------------
    // NOTE: the entry array has no reset. An entry is visible only through
    // entry_valid or the head of a drain, and both depend on count. Clearing
    // the array would cost a reset path to every storage bit and would change
    // no output.
    always_ff @(posedge clock) begin
        if (enq) begin
            addr_mem[tail] <= st_addr;
            data_mem[tail] <= st_data;
        end
    end

endmodule

// File: tb/tb_store_queue.sv
// -----------------------------------------------------------------------------
// tb_store_queue
//
// Self-checking bench for store_queue. The reference is a plain queue of
// {addr, data} stores. On each posedge, the reference drops its contents on
// reset, pops the front on a drain and pushes an accepted store. On each
// negedge, one compare process derives every DUT output from that queue and
// from the current inputs. Directed sequences pin the reference with literal
// expectations, and a randomized phase then exercises interleavings.
// -----------------------------------------------------------------------------
module tb_store_queue;

    localparam int DEPTH = 4;

    logic                   clock;
    logic                   reset;
    logic                   st_valid;
    logic [31:0]            st_addr;
    logic [7:0]             st_data;
    logic                   st_ready;
    logic                   ram_grant;
    logic                   ram_we;
    logic [31:0]            ram_addr;
    logic [7:0]             ram_w_data;
    logic [31:0]            chk_addr;
    logic                   chk_hit;
    logic [$clog2(DEPTH):0] count;
    logic                   empty;
    logic                   full;

    store_queue #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_ready   (st_ready),
        .ram_grant  (ram_grant),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_w_data (ram_w_data),
        .chk_addr   (chk_addr),
        .chk_hit    (chk_hit),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // -------------------------------------------------------------------------
    // Scoreboard bookkeeping
    // -------------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: the queue contents as a list of stores
    // -------------------------------------------------------------------------
    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } store_t;

    store_t      mq[$];
    bit          check_en = 1'b0;
    logic [31:0] dut_log[$];     // addresses that the DUT wrote to RAM

    always @(posedge clock) begin
        if (reset) begin
            mq.delete();
            check_en = 1'b1;
        end else if (check_en) begin
            bit     accept;
            bit     drain;
            store_t s;
            accept = st_valid && (mq.size() != DEPTH);
            drain  = ram_grant && (mq.size() != 0);
            if (drain) void'(mq.pop_front());
            if (accept) begin
                s.addr = st_addr;
                s.data = st_data;
                mq.push_back(s);
            end
        end
    end

    // One compare process: all outputs, every cycle after the first reset.
    always @(negedge clock) begin
        if (check_en) begin
            int          n;
            bit          exp_ready;
            bit          exp_we;
            bit          exp_hit;
            logic [31:0] exp_addr;
            logic [7:0]  exp_data;
            n         = mq.size();
            exp_ready = (n != DEPTH);
            exp_we    = !reset && ram_grant && (n != 0);
            exp_addr  = exp_we ? mq[0].addr : 32'h0;
            exp_data  = exp_we ? mq[0].data : 8'h0;
            exp_hit   = st_valid && exp_ready && (st_addr == chk_addr);
            foreach (mq[i]) if (mq[i].addr == chk_addr) exp_hit = 1'b1;

            check("m_count",    32'(count),      32'(n));
            check("m_empty",    32'(empty),      32'(n == 0));
            check("m_full",     32'(full),       32'(n == DEPTH));
            check("m_st_ready", 32'(st_ready),   32'(exp_ready));
            check("m_ram_we",   32'(ram_we),     32'(exp_we));
            check("m_ram_addr", ram_addr,        exp_addr);
            check("m_ram_data", 32'(ram_w_data), 32'(exp_data));
            check("m_chk_hit",  32'(chk_hit),    32'(exp_hit));
            if (ram_we === 1'b1) dut_log.push_back(ram_addr);
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Directed sequences followed by randomized traffic
    // -------------------------------------------------------------------------
    initial begin
        int  k;
        int  cycles;
        bit  acc;

        reset     = 1'b1;
        st_valid  = 1'b0;
        st_addr   = '0;
        st_data   = '0;
        ram_grant = 1'b1;
        chk_addr  = '0;
        cyc();
        check("rst_ram_we", 32'(ram_we), 32'd0);
        cyc();
        reset     = 1'b0;
        ram_grant = 1'b0;
        #1;
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_full",     32'(full),     32'd0);
        check("rst_st_ready", 32'(st_ready), 32'd1);
        check("rst_count",    32'(count),    32'd0);
        check("rst_chk_hit",  32'(chk_hit),  32'd0);

        // Single store: enqueue, then drain on the following cycle.
        st_valid  = 1'b1;
        st_addr   = 32'h100;
        st_data   = 8'hA5;
        ram_grant = 1'b1;
        #1;
        check("nobypass_we", 32'(ram_we), 32'd0);
        cyc();
        st_valid = 1'b0;
        #1;
        check("one_count", 32'(count),      32'd1);
        check("one_we",    32'(ram_we),     32'd1);
        check("one_addr",  ram_addr,        32'h100);
        check("one_data",  32'(ram_w_data), 32'hA5);
        cyc();
        check("one_empty", 32'(empty),  32'd1);
        check("one_we_0",  32'(ram_we), 32'd0);

        // Fill to full with no grant; a fifth store is refused.
        ram_grant = 1'b0;
        dut_log.delete();
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1;
            st_addr  = 32'h10 + 32'(i);
            st_data  = 8'(i + 1);
            cyc();
        end
        st_addr = 32'h14;
        st_data = 8'h55;
        #1;
        check("full_flag",   32'(full),     32'd1);
        check("full_ready",  32'(st_ready), 32'd0);
        check("full_count",  32'(count),    32'd4);
        cyc();
        check("refuse_count", 32'(count), 32'd4);

        // Full queue, store and drain in the same cycle: drain only.
        ram_grant = 1'b1;
        #1;
        check("fd_we",   32'(ram_we), 32'd1);
        check("fd_addr", ram_addr,    32'h10);
        cyc();
        ram_grant = 1'b0;
        #1;
        check("fd_count", 32'(count),    32'd3);
        check("fd_ready", 32'(st_ready), 32'd1);
        cyc();
        st_valid = 1'b0;
        #1;
        check("fd_accept", 32'(count), 32'd4);
        ram_grant = 1'b1;
        repeat (4) cyc();
        ram_grant = 1'b0;
        #1;
        check("fd_empty",    32'(empty),          32'd1);
        check("fd_log_size", 32'(dut_log.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < dut_log.size()) check("fd_order", dut_log[i], 32'h10 + 32'(i));
        end

        // Hazard check against pending and incoming stores.
        st_valid = 1'b1;
        st_addr  = 32'h200;
        st_data  = 8'h01;
        cyc();
        st_addr  = 32'h204;
        st_data  = 8'h02;
        cyc();
        st_valid = 1'b0;
        chk_addr = 32'h204;
        #1;
        check("hit_pending", 32'(chk_hit), 32'd1);
        chk_addr = 32'h208;
        #1;
        check("hit_miss", 32'(chk_hit), 32'd0);
        st_valid = 1'b1;
        st_addr  = 32'h208;
        #1;
        check("hit_incoming", 32'(chk_hit), 32'd1);
        st_valid  = 1'b0;
        ram_grant = 1'b1;
        repeat (2) cyc();
        ram_grant = 1'b0;
        chk_addr  = 32'h0;

        // Ten stores, grant toggling every cycle; the pointers wrap twice.
        dut_log.delete();
        k      = 0;
        cycles = 0;
        while ((k < 10 || count != 0) && cycles < 200) begin
            st_valid  = (k < 10);
            st_addr   = 32'h300 + 32'(4 * k);
            st_data   = 8'(k);
            ram_grant = cycles[0];
            #1;
            acc = st_valid && st_ready;
            cyc();
            if (acc) k++;
            cycles++;
        end
        st_valid  = 1'b0;
        ram_grant = 1'b0;
        #1;
        check("wrap_done",     32'(cycles < 200),   32'd1);
        check("wrap_count",    32'(count),          32'd0);
        check("wrap_log_size", 32'(dut_log.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < dut_log.size()) check("wrap_order", dut_log[i], 32'h300 + 32'(4 * i));
        end

        // Reset with three pending stores drops them without writing.
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1;
            st_addr  = 32'h500 + 32'(i);
            st_data  = 8'(i);
            cyc();
        end
        st_valid = 1'b0;
        #1;
        check("prst_count", 32'(count), 32'd3);
        reset     = 1'b1;
        ram_grant = 1'b1;
        #1;
        check("prst_we", 32'(ram_we), 32'd0);
        cyc();
        reset = 1'b0;
        #1;
        check("prst_empty", 32'(empty), 32'd1);
        check("prst_count0", 32'(count), 32'd0);
        dut_log.delete();
        repeat (5) cyc();
        check("prst_no_writes", 32'(dut_log.size()), 32'd0);

        // Randomized traffic on a small address pool, so that hits and
        // same-address stores are frequent.
        for (int c = 0; c < 500; c++) begin
            reset     = ($urandom_range(59) == 0);
            st_valid  = 1'($urandom_range(1));
            st_addr   = 32'h400 + 32'($urandom_range(7));
            st_data   = 8'($urandom);
            ram_grant = 1'($urandom_range(1));
            chk_addr  = 32'h400 + 32'($urandom_range(7));
            cyc();
        end
        reset     = 1'b0;
        st_valid  = 1'b0;
        ram_grant = 1'b1;
        repeat (DEPTH + 1) cyc();
        check("final_empty", 32'(empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
